fetch_sequencer: RTL
====================

# fetch_sequencer

Multi-cycle instruction fetch controller for the non-pipelined processor. Owns the program counter, drives the instruction memory through a request/ready handshake, and hands each fetched instruction to the execute stage through a valid/ready handshake. Handles branch/jump redirects, halt requests, memory timeouts and misaligned fetch addresses.

## Interface

- ADDR_WIDTH, 32, PC and instruction-memory address width
- RESET_PC, 32'h0000_0000, PC value after reset
- PC_STEP, 4, sequential PC increment in bytes
- MAX_WAIT, 15, maximum WAIT cycles without imem_ready before error (≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  begin fetching from current PC (sampled in IDLE only)
- imem_req  out  1  one-cycle fetch request strobe
- imem_addr  out  ADDR_WIDTH  fetch address (= PC register)
- imem_ready  in  1  memory data valid (sampled in WAIT only)
- imem_rdata  in  32  instruction word from memory
- instr_valid  out  1  instr/instr_pc hold a valid instruction
- instr  out  32  fetched instruction
- instr_pc  out  ADDR_WIDTH  address of instr
- instr_ready  in  1  execute stage accepts instruction
- redirect_valid  in  1  next PC comes from redirect_pc (sampled at handshake only)
- redirect_pc  in  ADDR_WIDTH  branch/jump target
- halt_req  in  1  stop after the current instruction is accepted
- halted  out  1  sequencer stopped by halt (sticky)
- fetch_error  out  1  timeout or misaligned fetch (sticky)

## Operation

- States: IDLE, REQ, WAIT, ISSUE, HALT, ERROR. All outputs registered or decoded from registered state.
- Reset (reset=0, any time, including mid-fetch): state IDLE, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, halted=0, fetch_error=0, wait_cnt=0, halt_pend=0. In-flight memory response is discarded.
- IDLE: halt_req=1 → HALT (priority over start); start=1 → REQ; else stay.
- REQ: imem_req=1 for exactly one cycle. If pc[1:0]≠0 → ERROR (imem_req stays 0). Else → WAIT, wait_cnt=0.
- WAIT: imem_ready=1 → latch instr=imem_rdata, instr_pc=pc, → ISSUE. Else wait_cnt++; if wait_cnt==MAX_WAIT-1 and no ready → ERROR.
- ISSUE: instr_valid=1; instr and instr_pc stable until handshake (instr_valid & instr_ready). On handshake: pc ← redirect_valid ? redirect_pc : pc+PC_STEP (modulo 2^ADDR_WIDTH, 32'hFFFF_FFFC+4 wraps to 0, no error); then → HALT if halt_req or halt_pend, else → REQ.
- halt_req in REQ/WAIT/ISSUE without handshake sets halt_pend; honoured at next ISSUE handshake. The in-flight instruction is always delivered.
- redirect_valid outside the handshake cycle is ignored.
- HALT: halted=1, instr_valid=0, no requests; exit only via reset. start ignored.
- ERROR: fetch_error=1, instr_valid=0, no requests; exit only via reset. pc holds faulting address.

## Timing

- start high at edge k → imem_req high in cycle k+1 → imem_ready earliest cycle k+2 → instr_valid earliest cycle k+3.
- imem_ready in the REQ cycle is ignored.
- Minimum per-instruction period: 3 cycles (REQ, WAIT, ISSUE) with zero-wait memory and instr_ready held high.
- Handshake at edge n → next imem_req in cycle n+1 with updated imem_addr.
- Timeout: ERROR entered after MAX_WAIT consecutive WAIT cycles without ready; ready in the MAX_WAIT-th WAIT cycle is accepted.
- Reset assertion takes effect immediately (async); deassertion is synchronised externally; first active edge after release sees IDLE.

## Test plan

- Sequential fetch: start, memory ready 1 cycle after every req, instr_ready=1 → imem_addr 0,4,8,12; instr_valid every 3rd cycle; instr_pc matches.
- Redirect and wrap: redirect_valid=1, redirect_pc=32'hFFFF_FFFC at handshake → next fetch at FFFF_FFFC, following fetch at 0, fetch_error=0.
- Backpressure and halt: hold instr_ready=0 for 5 cycles with halt_req pulsed during WAIT → instr stable 5 cycles, after handshake halted=1, no further imem_req.
- Timeout: MAX_WAIT=15, never assert imem_ready → fetch_error=1 after 15th WAIT cycle; ready on 15th cycle instead → normal ISSUE.
- Misalignment: redirect_pc=32'h0000_0006 → imem_req never asserted for 6, fetch_error=1, imem_addr=6.
- Reset mid-WAIT: reset=0 while waiting, then ready arrives → all outputs at reset values, pc=RESET_PC, late ready ignored, IDLE until start.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch controller: owns the PC, drives imem via req/ready
// and hands each instruction to execute via valid/ready, with redirect, halt and fault handling.
module fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4,
  parameter int                    MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt_req,
  output logic                  halted,
  output logic                  fetch_error
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ISSUE, S_HALT, S_ERROR} state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [31:0]           r_instr;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic [CW-1:0]         r_wait_cnt;
  logic                  r_halt_pend;

  logic w_hs, w_misalign, w_timeout, w_busy;

  assign w_hs       = (r_state == S_ISSUE) & instr_ready;
  assign w_misalign = r_pc[1:0] != 2'b00;
  assign w_timeout  = r_wait_cnt == CW'(MAX_WAIT - 1);
  assign w_busy     = (r_state == S_REQ) | (r_state == S_WAIT) | (r_state == S_ISSUE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (halt_req) w_next = S_HALT;
               else if (start) w_next = S_REQ;
      S_REQ:   w_next = w_misalign ? S_ERROR : S_WAIT;
      S_WAIT:  if (imem_ready) w_next = S_ISSUE;
               else if (w_timeout) w_next = S_ERROR;
      S_ISSUE: if (w_hs) w_next = (halt_req | r_halt_pend) ? S_HALT : S_REQ;
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_instr     <= '0;
      r_instr_pc  <= '0;
      r_wait_cnt  <= '0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_REQ:   r_wait_cnt <= '0;
        S_WAIT:  if (imem_ready) begin
                   r_instr    <= imem_rdata;
                   r_instr_pc <= r_pc;
                 end else begin
                   r_wait_cnt <= r_wait_cnt + CW'(1);
                 end
        // Sequential increment wraps modulo 2^ADDR_WIDTH by construction.
        S_ISSUE: if (w_hs) r_pc <= redirect_valid ? redirect_pc : r_pc + ADDR_WIDTH'(PC_STEP);
        default: ;
      endcase
      if (w_busy && halt_req && !w_hs) r_halt_pend <= 1'b1;
    end
  end

  // A misaligned PC must never reach memory, so the strobe is masked in REQ.
  assign imem_req    = (r_state == S_REQ) & ~w_misalign;
  assign imem_addr   = r_pc;
  assign instr_valid = r_state == S_ISSUE;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign halted      = r_state == S_HALT;
  assign fetch_error = r_state == S_ERROR;
endmodule
